regfile_write_arbiter: RTL and testbench

Write-port controller for the 32×32 MIPS register file. Two writeback sources, the ALU and the load unit, share the single write port through a round-robin arbiter. The block registers the granted write onto the register file's write port and keeps a 32-bit pending-write scoreboard. Decode uses that scoreboard to stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file, and it is the only driver of the register file's regWrite, writeRegister and writeData inputs.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 96 +++++++++
 tb/tb_regfile_write_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, grant encoding and hazard helper for the register-file write controller.
package regfile_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned NUM_REGS = 32;

   localparam logic [REG_W-1:0] ZERO_REG = '0;

   localparam logic GRANT_ALU = 1'b0;
   localparam logic GRANT_MEM = 1'b1;

   // A pending write to $0 can never exist, so $0 never causes a hazard.
   function automatic logic hazard(input logic [NUM_REGS-1:0] busy,
                                   input logic [REG_W-1:0]    r);
      return (r != ZERO_REG) && busy[r];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; req/gnt bit index follows the GRANT_* encoding.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       resetN,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       lastGrant
);

   logic last_grant_q;

   always_comb begin
      gnt = 2'b00;
      if (resetN) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == GRANT_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         last_grant_q <= GRANT_MEM;
      end else if (|gnt) begin
         last_grant_q <= gnt[1];
      end
   end

   assign lastGrant = last_grant_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port controller: arbitrates ALU/load writebacks and tracks
// pending writes so decode can stall on RAW/WAW hazards.
module regfile_write_arbiter
   import regfile_pkg::*;
(
   input  logic                clk,
   input  logic                resetN,
   input  logic                issueValid,
   input  logic [REG_W-1:0]    issueReg,
   input  logic [REG_W-1:0]    srcReg1,
   input  logic [REG_W-1:0]    srcReg2,
   output logic                stall,
   input  logic                aluValid,
   input  logic [REG_W-1:0]    aluReg,
   input  logic [DATA_W-1:0]   aluData,
   output logic                aluReady,
   input  logic                memValid,
   input  logic [REG_W-1:0]    memReg,
   input  logic [DATA_W-1:0]   memData,
   output logic                memReady,
   output logic                regWrite,
   output logic [REG_W-1:0]    writeRegister,
   output logic [DATA_W-1:0]   writeData,
   output logic [NUM_REGS-1:0] busy
);

   logic [1:0]          gnt;
   logic                last_grant;
   logic                any_gnt;
   logic [REG_W-1:0]    win_reg;
   logic [DATA_W-1:0]   win_data;
   logic                do_set;

   logic                reg_write_q;
   logic [REG_W-1:0]    write_register_q;
   logic [DATA_W-1:0]   write_data_q;
   logic [NUM_REGS-1:0] busy_q, busy_d;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .resetN    (resetN),
      .req       ({memValid, aluValid}),
      .gnt       (gnt),
      .lastGrant (last_grant)
   );

   assign aluReady = gnt[0];
   assign memReady = gnt[1];
   assign any_gnt  = |gnt;
   assign win_reg  = gnt[1] ? memReg  : aluReg;
   assign win_data = gnt[1] ? memData : aluData;

   // Registered busy only: a writeback in this cycle does not unstall until the next.
   assign stall  = resetN && issueValid &&
                   (hazard(busy_q, srcReg1) || hazard(busy_q, srcReg2) ||
                    hazard(busy_q, issueReg));
   assign do_set = issueValid && !stall && (issueReg != ZERO_REG);

   always_comb begin
      busy_d = busy_q;
      if (any_gnt && (win_reg != ZERO_REG)) begin
         busy_d[win_reg] = 1'b0;
      end
      // Applied after the clear so a same-register collision leaves the bit set.
      if (do_set) begin
         busy_d[issueReg] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         reg_write_q      <= 1'b0;
         write_register_q <= '0;
         write_data_q     <= '0;
         busy_q           <= '0;
      end else begin
         reg_write_q <= any_gnt && (win_reg != ZERO_REG);
         if (any_gnt && (win_reg != ZERO_REG)) begin
            write_register_q <= win_reg;
            write_data_q     <= win_data;
         end
         busy_q <= busy_d;
      end
   end

   assign regWrite      = reg_write_q;
   assign writeRegister = write_register_q;
   assign writeData     = write_data_q;
   assign busy          = busy_q;

   // Under contention the grant must go to the source not served last time.
   a_alternate : assert property (@(posedge clk) disable iff (!resetN)
      (aluValid && memValid) |-> (aluReady == (last_grant == GRANT_MEM)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   logic                clk = 1'b0;
   logic                resetN;
   logic                issueValid;
   logic [REG_W-1:0]    issueReg, srcReg1, srcReg2;
   logic                stall;
   logic                aluValid, memValid;
   logic [REG_W-1:0]    aluReg, memReg;
   logic [DATA_W-1:0]   aluData, memData;
   logic                aluReady, memReady;
   logic                regWrite;
   logic [REG_W-1:0]    writeRegister;
   logic [DATA_W-1:0]   writeData;
   logic [NUM_REGS-1:0] busy;

   int checks = 0;
   int failures = 0;
   logic [NUM_REGS-1:0] exp_busy;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk           (clk),
      .resetN        (resetN),
      .issueValid    (issueValid),
      .issueReg      (issueReg),
      .srcReg1       (srcReg1),
      .srcReg2       (srcReg2),
      .stall         (stall),
      .aluValid      (aluValid),
      .aluReg        (aluReg),
      .aluData       (aluData),
      .aluReady      (aluReady),
      .memValid      (memValid),
      .memReg        (memReg),
      .memData       (memData),
      .memReady      (memReady),
      .regWrite      (regWrite),
      .writeRegister (writeRegister),
      .writeData     (writeData),
      .busy          (busy)
   );

   // Inputs change 1 time unit after the rising edge; checks happen 2 units after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetN = 1'b0; aluValid = 1'b1; memValid = 1'b1;
      aluReg = 5'd1; memReg = 5'd2; aluData = 32'h1; memData = 32'h2;
      issueValid = 1'b1; issueReg = 5'd6; srcReg1 = 5'd0; srcReg2 = 5'd0;
      step(); step();
      #1;
      checks++; if (aluReady !== 1'b0) begin failures++; $display("FAIL rst_aluReady got=%b exp=0", aluReady); end
      checks++; if (memReady !== 1'b0) begin failures++; $display("FAIL rst_memReady got=%b exp=0", memReady); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
      checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL rst_regWrite got=%b exp=0", regWrite); end
      checks++; if (busy !== 32'h0) begin failures++; $display("FAIL rst_busy got=%h exp=0", busy); end
      checks++; if (writeRegister !== 5'd0 || writeData !== 32'h0) begin
         failures++; $display("FAIL rst_port got=%0d/%h exp=0/0", writeRegister, writeData);
      end
      step();
      resetN = 1'b1; memValid = 1'b0; issueValid = 1'b0;
      aluValid = 1'b1; aluReg = 5'd3; aluData = 32'hDEADBEEF;
      #1;
      checks++; if (aluReady !== 1'b1) begin failures++; $display("FAIL first_aluReady got=%b exp=1", aluReady); end
      step();
      aluValid = 1'b0; memValid = 1'b1; memReg = 5'd2; memData = 32'h0000_0022;
      #1;
      checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd3 || writeData !== 32'hDEADBEEF) begin
         failures++; $display("FAIL first_write got=%b/%0d/%h exp=1/3/deadbeef", regWrite, writeRegister, writeData);
      end
      checks++; if (memReady !== 1'b1) begin failures++; $display("FAIL mem_only_ready got=%b exp=1", memReady); end
      step();
      memValid = 1'b0;
      #1;
      checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd2 || writeData !== 32'h22) begin
         failures++; $display("FAIL mem_only_write got=%b/%0d/%h exp=1/2/22", regWrite, writeRegister, writeData);
      end
   endtask

   // lastGrant is MEM here, so contention must start with the ALU.
   task automatic test_contention();
      logic [1:0]        exp_gnt [4];
      logic [REG_W-1:0]  exp_reg [4];
      logic [DATA_W-1:0] exp_dat [4];
      int alu_n = 0;
      int mem_n = 0;
      exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_reg = '{5'd4, 5'd5, 5'd4, 5'd5};
      exp_dat = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
      for (int c = 0; c < 5; c++) begin
         aluValid = (c < 4); memValid = (c < 4);
         aluReg = 5'd4; memReg = 5'd5;
         aluData = 32'hA000_0000 | alu_n; memData = 32'hB000_0000 | mem_n;
         #1;
         if (c < 4) begin
            checks++;
            if ({memReady, aluReady} !== exp_gnt[c]) begin
               failures++; $display("FAIL cont_grant[%0d] got=%b exp=%b", c, {memReady, aluReady}, exp_gnt[c]);
            end
         end
         if (c > 0) begin
            checks++;
            if (regWrite !== 1'b1 || writeRegister !== exp_reg[c-1] || writeData !== exp_dat[c-1]) begin
               failures++;
               $display("FAIL cont_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", c, regWrite, writeRegister,
                        writeData, exp_reg[c-1], exp_dat[c-1]);
            end
         end
         if (aluReady) alu_n++;
         if (memReady) mem_n++;
         step();
      end
      aluValid = 1'b0; memValid = 1'b0;
      #1;
      checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL cont_idle got=%b exp=0", regWrite); end
   endtask

   task automatic test_raw();
      issueValid = 1'b1; issueReg = 5'd8; srcReg1 = 5'd0; srcReg2 = 5'd0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_c0_stall got=%b exp=0", stall); end
      step();
      issueReg = 5'd12; srcReg1 = 5'd8;
      #1;
      checks++; if (busy !== 32'h0000_0100) begin failures++; $display("FAIL raw_c1_busy got=%h exp=00000100", busy); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_c1_stall got=%b exp=1", stall); end
      step();
      memValid = 1'b1; memReg = 5'd8; memData = 32'h88;
      #1;
      checks++; if (memReady !== 1'b1) begin failures++; $display("FAIL raw_c2_memReady got=%b exp=1", memReady); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_c2_nobypass got=%b exp=1", stall); end
      step();
      memValid = 1'b0;
      #1;
      checks++; if (busy !== 32'h0) begin failures++; $display("FAIL raw_c3_busy got=%h exp=0", busy); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_c3_stall got=%b exp=0", stall); end
      checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd8 || writeData !== 32'h88) begin
         failures++; $display("FAIL raw_c3_write got=%b/%0d/%h exp=1/8/88", regWrite, writeRegister, writeData);
      end
      step();
      issueValid = 1'b0; srcReg1 = 5'd0;
      exp_busy = 32'h0000_1000;
      #1;
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL raw_issue12 got=%h exp=%h", busy, exp_busy); end
   endtask

   task automatic test_zero_waw();
      aluValid = 1'b1; aluReg = 5'd0; aluData = 32'h55;
      issueValid = 1'b1; issueReg = 5'd9; srcReg1 = 5'd0; srcReg2 = 5'd0;
      #1;
      checks++; if (aluReady !== 1'b1) begin failures++; $display("FAIL zero_aluReady got=%b exp=1", aluReady); end
      step();
      aluValid = 1'b0;
      exp_busy = exp_busy | 32'h0000_0200;
      #1;
      checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL zero_regWrite got=%b exp=0", regWrite); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL zero_busy got=%h exp=%h", busy, exp_busy); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall); end
      step();
      issueReg = 5'd0; srcReg2 = 5'd12;
      #1;
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL waw_busy got=%h exp=%h", busy, exp_busy); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL src2_stall got=%b exp=1", stall); end
      srcReg2 = 5'd0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL issue_r0_stall got=%b exp=0", stall); end
      step();
      issueValid = 1'b0;
      #1;
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL issue_r0_busy got=%h exp=%h", busy, exp_busy); end
   endtask

   task automatic test_collision();
      issueValid = 1'b1; issueReg = 5'd10; srcReg1 = 5'd0; srcReg2 = 5'd0;
      aluValid = 1'b1; aluReg = 5'd10; aluData = 32'h1010;
      #1;
      checks++; if (stall !== 1'b0 || aluReady !== 1'b1) begin
         failures++; $display("FAIL coll_grant got=%b/%b exp=0/1", stall, aluReady);
      end
      step();
      aluValid = 1'b0;
      issueReg = 5'd13;
      memValid = 1'b1; memReg = 5'd9; memData = 32'h0909;
      exp_busy = exp_busy | 32'h0000_0400;
      #1;
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL coll_busy got=%h exp=%h", busy, exp_busy); end
      checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd10 || writeData !== 32'h1010) begin
         failures++; $display("FAIL coll_write got=%b/%0d/%h exp=1/10/1010", regWrite, writeRegister, writeData);
      end
      step();
      issueValid = 1'b0; memValid = 1'b0;
      exp_busy = (exp_busy & ~32'h0000_0200) | 32'h0000_2000;
      #1;
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL diff_busy got=%h exp=%h", busy, exp_busy); end
   endtask

   task automatic test_reset_mid();
      aluValid = 1'b1; aluReg = 5'd14; aluData = 32'h77;
      #1;
      checks++; if (aluReady !== 1'b1) begin failures++; $display("FAIL mid_grant got=%b exp=1", aluReady); end
      step();
      resetN = 1'b0; aluReg = 5'd15; aluData = 32'h99; memValid = 1'b1; memReg = 5'd16;
      #1;
      checks++; if (aluReady !== 1'b0 || memReady !== 1'b0) begin
         failures++; $display("FAIL mid_ready got=%b/%b exp=0/0", aluReady, memReady);
      end
      checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd14) begin
         failures++; $display("FAIL mid_prewrite got=%b/%0d exp=1/14", regWrite, writeRegister);
      end
      step();
      resetN = 1'b1;
      #1;
      checks++; if (regWrite !== 1'b0 || busy !== 32'h0 || writeRegister !== 5'd0) begin
         failures++; $display("FAIL mid_after got=%b/%h/%0d exp=0/0/0", regWrite, busy, writeRegister);
      end
      checks++; if (aluReady !== 1'b1 || memReady !== 1'b0) begin
         failures++; $display("FAIL mid_conflict1 got=%b%b exp=01", memReady, aluReady);
      end
      step();
      aluReg = 5'd17;
      #1;
      checks++; if (aluReady !== 1'b0 || memReady !== 1'b1) begin
         failures++; $display("FAIL mid_conflict2 got=%b%b exp=10", memReady, aluReady);
      end
      step();
      aluValid = 1'b0; memValid = 1'b0;
   endtask

   initial begin
      resetN = 1'b0; issueValid = 1'b0; issueReg = '0; srcReg1 = '0; srcReg2 = '0;
      aluValid = 1'b0; aluReg = '0; aluData = '0;
      memValid = 1'b0; memReg = '0; memData = '0;
      exp_busy = '0;
      #1;
      test_reset();
      test_contention();
      test_raw();
      test_zero_waw();
      test_collision();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
